// File: rtl/ifu_fetch_pkg.sv
// Shared encodings for the instruction-fetch unit: FSM states and default reset PC.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the architectural PC, issues fetch requests and holds
// the returned instruction for decode until it retires, then loads the next PC.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      npc_i,
    output logic [31:0]      pc_o,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             inst_valid_o,
    output logic [31:0]      inst_o,
    input  logic             inst_ready_i,
    input  logic             halt_i,
    output logic             misalign_o,
    output logic [CNT_W-1:0] retired_o
);

    ifu_state_e state, state_nxt;
    logic       req_pending;
    logic       retire;
    logic       npc_misaligned;

    assign npc_misaligned = (npc_i[1:0] != 2'b00);
    assign retire         = (state == S_HOLD) && inst_ready_i;
    assign imem_addr      = pc_o;
    assign inst_valid_o   = (state == S_HOLD);

    // A request already presented must not be withdrawn, so halt only gates fresh ones.
    // The rstn term keeps the request low while reset is asserted.
    always_comb begin
        imem_req_valid = 1'b0;
        if (rstn && state == S_REQ) begin
            imem_req_valid = req_pending || !halt_i;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    state_nxt = S_WAIT;
                end else if (halt_i && !req_pending) begin
                    state_nxt = S_HALT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready_i) begin
                    state_nxt = npc_misaligned ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                if (!halt_i && !misalign_o) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_REQ;
            req_pending <= 1'b0;
            pc_o        <= RESET_PC;
            inst_o      <= 32'h0;
            misalign_o  <= 1'b0;
            retired_o   <= '0;
        end else begin
            state       <= state_nxt;
            req_pending <= imem_req_valid && !imem_req_ready;
            if (state == S_WAIT && imem_rsp_valid) begin
                inst_o <= imem_rsp_data;
            end
            if (retire) begin
                retired_o <= retired_o + {{(CNT_W-1){1'b0}}, 1'b1};
                if (npc_misaligned) begin
                    misalign_o <= 1'b1;
                end else begin
                    pc_o <= npc_i;
                end
            end
        end
    end

endmodule
